// File: rtl/ping_tof_avg.sv
// Multi-channel ping time-of-flight averager: fires a ping each window, records first/last
// receive strobe per channel, and averages a mode-selected per-window value over a batch.
module ping_tof_avg #(
  parameter int CH       = 2,
  parameter int WIN_LOG2 = 12,
  parameter int AVG_LOG2 = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           cont,
  input  logic [1:0]                     mode,
  input  logic [CH-1:0]                  rx_stb,
  output logic                           tx_stb,
  output logic                           busy,
  output logic                           res_vld,
  output logic [CH*(WIN_LOG2+1)-1:0]     result,
  output logic [CH*(AVG_LOG2+1)-1:0]     hits
);

  localparam int ACC_W = WIN_LOG2 + AVG_LOG2;
  localparam int RES_W = WIN_LOG2 + 1;
  localparam int HIT_W = AVG_LOG2 + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              r_state, w_state_next;
  logic [WIN_LOG2-1:0] r_w;
  logic [AVG_LOG2-1:0] r_k;
  logic [1:0]          r_mode;
  logic                r_res_vld;
  logic                w_win_end, w_batch_end, w_advance, w_launch;

  assign w_win_end   = &r_w;
  assign w_batch_end = w_win_end && (&r_k);
  assign w_advance   = (r_state == S_RUN) && !stop;
  // Mode is captured on a fresh start and again on an automatic restart.
  assign w_launch    = ((r_state == S_IDLE) && start && !stop) ||
                       (w_advance && w_batch_end && cont);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start && !stop) w_state_next = S_RUN;
      S_RUN: begin
        if (stop)                       w_state_next = S_IDLE;
        else if (w_batch_end && !cont)  w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w       <= '0;
      r_k       <= '0;
      r_mode    <= '0;
      r_res_vld <= 1'b0;
    end else begin
      r_res_vld <= w_advance && w_batch_end;
      if (w_launch) r_mode <= mode;
      if (w_advance) begin
        r_w <= r_w + 1'b1;
        if (w_win_end) r_k <= r_k + 1'b1;
      end else begin
        r_w <= '0;
        r_k <= '0;
      end
    end
  end

  assign tx_stb  = (r_state == S_RUN) && (r_w == '0);
  assign busy    = (r_state == S_RUN);
  assign res_vld = r_res_vld;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic                r_seen;
    logic [WIN_LOG2-1:0] r_first, r_last;
    logic [ACC_W-1:0]    r_acc;
    logic [HIT_W-1:0]    r_hit, r_hits;
    logic [RES_W-1:0]    r_result;

    logic                w_seen;
    logic [WIN_LOG2-1:0] w_first, w_last;
    logic [WIN_LOG2:0]   w_sum, w_val;
    logic [ACC_W-1:0]    w_acc_next;
    logic [HIT_W-1:0]    w_hit_next;

    // Fold the current cycle's strobe in so the last cycle of a window is counted.
    always_comb begin
      w_seen  = r_seen | rx_stb[gi];
      w_first = r_seen ? r_first : r_w;
      w_last  = rx_stb[gi] ? r_w : r_last;
      w_sum   = {1'b0, w_first} + {1'b0, w_last};
      case (r_mode)
        2'd0:    w_val = {1'b0, w_first};
        2'd1:    w_val = {1'b0, w_last};
        2'd2:    w_val = w_sum >> 1;
        default: w_val = {1'b0, w_last - w_first};
      endcase
      w_acc_next = r_acc + (w_seen ? {{(AVG_LOG2-1){1'b0}}, w_val} : {ACC_W{1'b0}});
      w_hit_next = r_hit + {{AVG_LOG2{1'b0}}, w_seen};
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_seen   <= 1'b0;
        r_first  <= '0;
        r_last   <= '0;
        r_acc    <= '0;
        r_hit    <= '0;
        r_hits   <= '0;
        r_result <= '0;
      end else if (w_advance) begin
        if (w_win_end) begin
          r_seen <= 1'b0;
          if (w_batch_end) begin
            r_acc    <= '0;
            r_hit    <= '0;
            r_result <= {1'b0, w_acc_next[ACC_W-1:AVG_LOG2]};
            r_hits   <= w_hit_next;
          end else begin
            r_acc <= w_acc_next;
            r_hit <= w_hit_next;
          end
        end else if (rx_stb[gi]) begin
          r_seen <= 1'b1;
          r_last <= r_w;
          if (!r_seen) r_first <= r_w;
        end
      end else begin
        r_seen <= 1'b0;
        r_acc  <= '0;
        r_hit  <= '0;
      end
    end

    assign result[gi*RES_W +: RES_W] = r_result;
    assign hits[gi*HIT_W +: HIT_W]   = r_hits;
  end

endmodule

// File: tb/tb_ping_tof_avg.sv
// Bench for ping_tof_avg: per-batch strobe log model, per-cycle output comparison,
// directed scenarios with literal expectations plus randomized batches.
module tb_ping_tof_avg;
  localparam int CH = 2, WL = 4, AL = 2;
  localparam int NW = 16, NK = 4, NT = 64;
  localparam int RW = WL + 1, HW = AL + 1;

  logic              clk = 1'b0, rst = 1'b0;
  logic              start = 1'b0, stop = 1'b0, cont = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [CH-1:0]     rx_stb = '0;
  logic              tx_stb, busy, res_vld;
  logic [CH*RW-1:0]  result;
  logic [CH*HW-1:0]  hits;

  ping_tof_avg #(.CH(CH), .WIN_LOG2(WL), .AVG_LOG2(AL)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont), .mode(mode),
    .rx_stb(rx_stb), .tx_stb(tx_stb), .busy(busy), .res_vld(res_vld),
    .result(result), .hits(hits)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int dres(input int ch);
    return int'(result[ch*RW +: RW]);
  endfunction
  function automatic int dhits(input int ch);
    return int'(hits[ch*HW +: HW]);
  endfunction

  // Reference model: logs first/last strobe offsets per window, evaluates at batch end.
  bit m_run = 0;
  int m_t = 0, m_md = 0;
  int m_first[CH][NK], m_last[CH][NK];
  int e_res[CH], e_hits[CH];
  bit e_vld = 0;

  function automatic void clear_windows();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < NK; k++) begin
        m_first[c][k] = -1;
        m_last[c][k]  = -1;
      end
  endfunction

  function automatic void finish_batch();
    for (int c = 0; c < CH; c++) begin
      int acc, h, v;
      acc = 0; h = 0;
      for (int k = 0; k < NK; k++) begin
        if (m_first[c][k] >= 0) begin
          case (m_md)
            0: v = m_first[c][k];
            1: v = m_last[c][k];
            2: v = (m_first[c][k] + m_last[c][k]) / 2;
            default: v = m_last[c][k] - m_first[c][k];
          endcase
          acc += v;
          h++;
        end
      end
      e_res[c]  = acc / NK;
      e_hits[c] = h;
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_t = 0; e_vld = 0;
      for (int c = 0; c < CH; c++) begin e_res[c] = 0; e_hits[c] = 0; end
    end else begin
      e_vld = 0;
      if (!m_run) begin
        if (start && !stop) begin
          m_run = 1; m_t = 0; m_md = int'(mode); clear_windows();
        end
      end else if (stop) begin
        m_run = 0;
      end else begin
        for (int c = 0; c < CH; c++)
          if (rx_stb[c]) begin
            if (m_first[c][m_t / NW] < 0) m_first[c][m_t / NW] = m_t % NW;
            m_last[c][m_t / NW] = m_t % NW;
          end
        if (m_t == NT - 1) begin
          finish_batch();
          e_vld = 1;
          if (cont) begin m_t = 0; m_md = int'(mode); clear_windows(); end
          else m_run = 0;
        end else begin
          m_t++;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy", int'(busy), int'(m_run));
    check("tx_stb", int'(tx_stb), int'(m_run && (m_t % NW == 0)));
    check("res_vld", int'(res_vld), int'(e_vld));
    for (int c = 0; c < CH; c++) begin
      check($sformatf("result_ch%0d", c), dres(c), e_res[c]);
      check($sformatf("hits_ch%0d", c), dhits(c), e_hits[c]);
    end
    if (res_vld)
      $display("batch done at %0t: ch0 result=%0d hits=%0d, ch1 result=%0d hits=%0d",
               $time, dres(0), dhits(0), dres(1), dhits(1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CH-1:0] pat(input int sc, input int t);
    int w, k;
    logic [CH-1:0] r;
    w = t % NW;
    k = (t / NW) % NK;
    r = '0;
    case (sc)
      0: r[0] = (w == 5);
      1: r[1] = (w == 3) || (w == 10);
      2: r[0] = (w == 8) && (k == 0 || k == 2);
      3: begin r[0] = (w == 0) || (w == 15); r[1] = r[0]; end
      default: for (int c = 0; c < CH; c++) r[c] = ($urandom_range(0, 4) == 0);
    endcase
    return r;
  endfunction

  task automatic drive(input logic [1:0] m, input int sc, input int ncyc, input int stop_at,
                       input int cont_until, input int chg_at, input logic [1:0] m2);
    mode  = m;
    cont  = (cont_until > 0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      rx_stb = pat(sc, t);
      if (t == chg_at) mode = m2;
      if (t == cont_until) cont = 1'b0;
      stop = (t == stop_at);
      if (sc == 4) start = ($urandom_range(0, 9) == 0);
      step();
      if (t == stop_at) break;
    end
    rx_stb = '0; stop = 1'b0; start = 1'b0; cont = 1'b0;
    step();
    step();
  endtask

  task automatic pin(input string nm, input int ch, input int r, input int h);
    check({nm, "_model_result"}, e_res[ch], r);
    check({nm, "_model_hits"}, e_hits[ch], h);
    check({nm, "_dut_result"}, dres(ch), r);
    check({nm, "_dut_hits"}, dhits(ch), h);
  endtask

  initial begin
    repeat (3) step();
    check("reset_busy", int'(busy), 0);
    check("reset_tx", int'(tx_stb), 0);
    check("reset_result", int'(result), 0);
    check("reset_hits", int'(hits), 0);
    rst = 1'b1;
    step();

    drive(2'd0, 0, NT, -1, -1, -1, 2'd0);
    pin("m0_w5_ch0", 0, 5, 4);
    pin("m0_w5_ch1", 1, 0, 0);
    drive(2'd2, 1, NT, -1, -1, -1, 2'd0);
    pin("m2_ch1", 1, 6, 4);
    drive(2'd3, 1, NT, -1, -1, -1, 2'd0);
    pin("m3_ch1", 1, 7, 4);
    drive(2'd0, 2, NT, -1, -1, -1, 2'd0);
    pin("half_ch0", 0, 4, 2);
    pin("none_ch1", 1, 0, 0);
    drive(2'd3, 3, NT, -1, -1, -1, 2'd0);
    pin("edge_m3_ch0", 0, 15, 4);
    pin("edge_m3_ch1", 1, 15, 4);
    drive(2'd1, 3, NT, -1, -1, -1, 2'd0);
    pin("edge_m1_ch0", 0, 15, 4);

    drive(2'd2, 0, NT, 40, -1, -1, 2'd0);
    check("stop_busy", int'(busy), 0);
    pin("stop_keep_ch0", 0, 15, 4);

    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    step();
    check("start_stop_idle", int'(busy), 0);

    drive(2'd0, 1, 2 * NT, -1, NT, 30, 2'd3);
    pin("cont_b2_ch1", 1, 7, 4);

    for (int i = 0; i < 8; i++) begin
      bit c2;
      c2 = ($urandom_range(0, 1) == 1);
      drive(2'($urandom_range(0, 3)), 4, c2 ? 2 * NT : NT,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NT - 1)) : -1,
            c2 ? NT : -1, int'($urandom_range(0, NT - 1)), 2'($urandom_range(0, 3)));
    end

    mode = 2'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 20; t++) begin rx_stb = pat(4, t); step(); end
    #2 rst = 1'b0;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_tx", int'(tx_stb), 0);
    check("async_vld", int'(res_vld), 0);
    check("async_result", int'(result), 0);
    check("async_hits", int'(hits), 0);
    rx_stb = '0;
    step();
    step();
    rst = 1'b1;
    repeat (3) step();
    check("post_reset_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ping_tof_avg.md
PING_TOF_AVG -- requirements
Module: ping_tof_avg

Interface
REQ-001 SHALL have parameter CH, default 2: number of receive channels.
REQ-002 SHALL have parameter WIN_LOG2, default 12: ping window length is 2^WIN_LOG2 cycles.
REQ-003 SHALL have parameter AVG_LOG2, default 4: each batch is 2^AVG_LOG2 windows.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset; the block is in reset while rst=0.
REQ-006 SHALL have port start, input, 1: one-cycle request to begin a batch.
REQ-007 SHALL have port stop, input, 1: abort request.
REQ-008 SHALL have port cont, input, 1: when 1, a new batch starts automatically after each batch completes.
REQ-009 SHALL have port mode, input, 2: measurement mode, sampled at batch start.
REQ-010 SHALL have port rx_stb, input, CH: per-channel receive strobes, one bit per channel.
REQ-011 SHALL have port tx_stb, output, 1: ping trigger pulse.
REQ-012 SHALL have port busy, output, 1: a batch is in progress.
REQ-013 SHALL have port res_vld, output, 1: one-cycle pulse when results update.
REQ-014 SHALL have port result, output, CH*(WIN_LOG2+1): per-channel averaged value, packed with channel 0 in the LSBs.
REQ-015 SHALL have port hits, output, CH*(AVG_LOG2+1): per-channel count of windows that contained at least one strobe.

Function
REQ-016 SHALL implement states IDLE and RUN.
- IDLE->RUN: start=1 and stop=0.
- RUN->IDLE: stop=1, or batch end with cont=0.
- RUN->RUN: batch end with cont=1.
REQ-017 SHALL, in RUN, run window offset w from 0 to 2^WIN_LOG2-1 and wrap to 0; w SHALL be 0 on the first RUN cycle.
REQ-018 SHALL run window index k from 0 to 2^AVG_LOG2-1, incrementing when w wraps.
REQ-019 SHALL assert tx_stb for exactly one cycle, in every RUN cycle where w=0.
REQ-020 SHALL, for each channel in a window, record first = w at the first strobe and last = w at the latest strobe. A strobe at w=0 and a strobe at the final w both count.
REQ-021 SHALL, on the final cycle of each window, accumulate per channel (that cycle's strobe included) only if the channel saw a strobe in that window. The per-window value depends on mode:
- 0: first
- 1: last
- 2: (first+last)>>1, truncated
- 3: last-first
REQ-022 SHALL increment that channel's hit counter for each window that contributes.
REQ-023 SHALL make each accumulator WIN_LOG2+AVG_LOG2 bits wide; it cannot overflow.
REQ-024 SHALL, on the final cycle of window k=2^AVG_LOG2-1:
- one cycle later, update result to acc>>AVG_LOG2 (truncated; divisor is the window count, not hits) and update hits;
- pulse res_vld for 1 cycle;
- clear the accumulators and hit counters.
REQ-025 SHALL hold result and hits stable between res_vld pulses, including while IDLE.
REQ-026 SHALL ignore start while RUN.
REQ-027 SHALL give stop priority when start and stop are asserted in the same cycle.
REQ-028 SHALL, on stop in RUN, return to IDLE next cycle, discard the partial batch, produce no res_vld, and leave result and hits unchanged.
REQ-029 SHALL, with cont=1, start the next batch on the cycle after the final window: w=0, tx_stb=1, mode re-sampled, no gap cycle.
REQ-030 SHALL ignore rx_stb while IDLE.
REQ-031 SHALL give busy=1 exactly while in RUN.

Reset
REQ-032 SHALL, while rst=0, immediately and asynchronously force:
- state IDLE;
- tx_stb=0, busy=0, res_vld=0;
- result=0, hits=0;
- all counters and accumulators 0.
REQ-033 SHALL discard any batch in progress when reset is asserted mid-batch, and SHALL require a new start after release.

Verification (CH=2, WIN_LOG2=4, AVG_LOG2=2)
REQ-034 SHALL cover: mode 0, start, ch0 strobe at w=5 in all 4 windows -> tx_stb at cycles 0,16,32,48; res_vld 1 cycle after cycle 63; ch0 result=5, hits=4.
REQ-035 SHALL cover: mode 2, ch1 strobes at w=3 and w=10 in every window -> ch1 result=6; mode 3 with the same stimulus -> result=7.
REQ-036 SHALL cover: ch0 strobes only in 2 of 4 windows, at w=8 -> result=4, hits=2; a channel with no strobes -> result=0, hits=0.
REQ-037 SHALL cover: strobes at w=0 and w=15, mode 3 -> result=15; mode 1 -> result=15.
REQ-038 SHALL cover: stop at cycle 40 -> busy=0 at cycle 41, no res_vld, previous result retained; start and stop in the same cycle -> stays IDLE.
REQ-039 SHALL cover: cont=1, mode changed during batch 1 -> batch 2 tx_stb immediately after batch 1's final cycle, batch 2 uses new mode; rst=0 mid-batch -> all outputs 0 asynchronously.
